// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg
//   Shared definitions for the iterative RV32M multiply/divide unit:
//   funct3 operation codes, the controller state encoding and a small
//   helper that tells divide-class operations apart from multiplies.
package alu_muldiv_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  // Divide and remainder operations all have funct3[2] set
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_cneg.sv
// alu_muldiv_cneg
//   Conditional two's-complement negator. Used to turn signed operands into
//   magnitudes and to restore the sign of the finished product/quotient/
//   remainder.
//   Ports:
//     value  [WIDTH-1:0] in   value to (optionally) negate
//     negate             in   1: output -value, 0: output value
//     result [WIDTH-1:0] out  combinational result
module alu_muldiv_cneg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
//   Iterative RV32M multiply/divide unit. Accepts one operation at a time over
//   a valid/ready handshake, runs DWIDTH radix-2 steps (shift-add multiply or
//   restoring divide on operand magnitudes), applies sign correction and the
//   divide-by-zero / signed-overflow overrides in a single FIXUP cycle, then
//   holds the registered result until the consumer takes it.
//   Optional build macro ALU_MULDIV_FASTPATH_EN: divide-by-zero, signed
//   overflow and multiplies by zero skip straight from IDLE to DONE with the
//   same result value they would otherwise produce.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     flush      in   abort any operation and return to IDLE
//     in_valid   in   op/op_a/op_b valid
//     in_ready   out  unit can accept (IDLE and not flushing)
//     op  [2:0]  in   RV32M funct3
//     op_a, op_b in   rs1 / rs2 operands
//     out_valid  out  result valid (DONE and not flushing)
//     out_ready  in   consumer takes the result
//     result     out  registered result
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] result
);

  localparam logic [DWIDTH-1:0] ZERO_W    = {DWIDTH{1'b0}};
  localparam logic [DWIDTH-1:0] ONES_W    = {DWIDTH{1'b1}};
  localparam logic [DWIDTH-1:0] MIN_W     = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(DWIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e             state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [2:0]            op_r;
  logic                  sa_r;
  logic                  sb_r;
  logic                  div_zero_r;
  logic                  ovf_r;
  logic [DWIDTH-1:0]     a_raw_r;
  logic [DWIDTH-1:0]     b_mag_r;
  // Multiply: {high partial, multiplier}; divide: {remainder, quotient}
  logic [2*DWIDTH-1:0]   acc_r;

  logic                  a_signed_s;
  logic                  b_signed_s;
  logic                  a_neg_s;
  logic                  b_neg_s;
  logic [DWIDTH-1:0]     a_mag_s;
  logic [DWIDTH-1:0]     b_mag_s;
  logic                  b_zero_s;
  logic                  in_ovf_s;
  logic [DWIDTH:0]       mul_sum_s;
  logic [2*DWIDTH-1:0]   mul_next_s;
  logic [DWIDTH:0]       div_tmp_s;
  logic                  div_ge_s;
  logic [DWIDTH-1:0]     div_diff_s;
  logic [2*DWIDTH-1:0]   div_next_s;
  logic [2*DWIDTH-1:0]   prod_s;
  logic [DWIDTH-1:0]     qr_val_s;
  logic                  qr_neg_s;
  logic [DWIDTH-1:0]     qr_s;
  logic [DWIDTH-1:0]     fix_result_s;
  logic                  fast_s;
  logic [DWIDTH-1:0]     fast_result_s;

  assign in_ready  = (state_r == IDLE) && !flush;
  assign out_valid = (state_r == DONE) && !flush;

  // Operand signedness and magnitudes at accept
  assign a_signed_s = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign b_signed_s = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign a_neg_s    = a_signed_s && op_a[DWIDTH-1];
  assign b_neg_s    = b_signed_s && op_b[DWIDTH-1];
  assign b_zero_s   = (op_b == ZERO_W);
  assign in_ovf_s   = ((op == MD_DIV) || (op == MD_REM)) && (op_a == MIN_W) && (op_b == ONES_W);

  alu_muldiv_cneg #(.WIDTH(DWIDTH)) u_mag_a (.value(op_a), .negate(a_neg_s), .result(a_mag_s));
  alu_muldiv_cneg #(.WIDTH(DWIDTH)) u_mag_b (.value(op_b), .negate(b_neg_s), .result(b_mag_s));

  // Shift-add step: conditionally add multiplicand into the high half,
  // then shift the whole accumulator right (carry enters at the top).
  assign mul_sum_s  = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]} + {1'b0, b_mag_r};
  assign mul_next_s = acc_r[0] ? {mul_sum_s, acc_r[DWIDTH-1:1]}
                               : {1'b0, acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-1:1]};

  // Restoring step: shift next dividend bit into the remainder and subtract
  // when it fits. The difference is below the divisor so DWIDTH bits suffice.
  assign div_tmp_s  = {acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-1]};
  assign div_ge_s   = (div_tmp_s >= {1'b0, b_mag_r});
  assign div_diff_s = div_tmp_s[DWIDTH-1:0] - b_mag_r;
  assign div_next_s = div_ge_s ? {div_diff_s, acc_r[DWIDTH-2:0], 1'b1}
                               : {div_tmp_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b0};

  // Sign restoration: product and quotient take sa^sb, remainder takes sa
  alu_muldiv_cneg #(.WIDTH(2*DWIDTH)) u_prod (.value(acc_r), .negate(sa_r ^ sb_r), .result(prod_s));
  assign qr_val_s = op_r[1] ? acc_r[2*DWIDTH-1:DWIDTH] : acc_r[DWIDTH-1:0];
  assign qr_neg_s = op_r[1] ? sa_r : (sa_r ^ sb_r);
  alu_muldiv_cneg #(.WIDTH(DWIDTH)) u_qr (.value(qr_val_s), .negate(qr_neg_s), .result(qr_s));

  // Final result selection including divide-by-zero / overflow overrides
  always_comb begin
    fix_result_s = ZERO_W;
    case (op_r)
      MD_MUL: fix_result_s = prod_s[DWIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result_s = prod_s[2*DWIDTH-1:DWIDTH];
      MD_DIV, MD_DIVU: begin
        if (div_zero_r) begin
          fix_result_s = ONES_W;
        end else if (ovf_r) begin
          fix_result_s = a_raw_r;
        end else begin
          fix_result_s = qr_s;
        end
      end
      MD_REM, MD_REMU: begin
        if (div_zero_r) begin
          fix_result_s = a_raw_r;
        end else if (ovf_r) begin
          fix_result_s = ZERO_W;
        end else begin
          fix_result_s = qr_s;
        end
      end
      default: fix_result_s = ZERO_W;
    endcase
  end

`ifdef ALU_MULDIV_FASTPATH_EN
  // Operations whose result is known at accept skip the iteration
  always_comb begin
    fast_s        = 1'b0;
    fast_result_s = ZERO_W;
    if (is_div(op)) begin
      if (b_zero_s) begin
        fast_s        = 1'b1;
        fast_result_s = op[1] ? op_a : ONES_W;
      end else if (in_ovf_s) begin
        fast_s        = 1'b1;
        fast_result_s = op[1] ? ZERO_W : op_a;
      end else begin
        fast_s        = 1'b0;
        fast_result_s = ZERO_W;
      end
    end else begin
      if ((op_a == ZERO_W) || b_zero_s) begin
        fast_s        = 1'b1;
        fast_result_s = ZERO_W;
      end else begin
        fast_s        = 1'b0;
        fast_result_s = ZERO_W;
      end
    end
  end
`else
  assign fast_s        = 1'b0;
  assign fast_result_s = ZERO_W;
`endif

  // Controller, datapath registers and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      op_r       <= 3'b000;
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      a_raw_r    <= ZERO_W;
      b_mag_r    <= ZERO_W;
      acc_r      <= {2*DWIDTH{1'b0}};
      result     <= ZERO_W;
    end else if (flush) begin
      // Discard in-flight work; result keeps its previous value
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r       <= op;
            sa_r       <= a_neg_s;
            sb_r       <= b_neg_s;
            div_zero_r <= b_zero_s;
            ovf_r      <= in_ovf_s;
            a_raw_r    <= op_a;
            b_mag_r    <= b_mag_s;
            acc_r      <= {ZERO_W, a_mag_s};
            cnt_r      <= CNT_START;
            if (fast_s) begin
              result  <= fast_result_s;
              state_r <= DONE;
            end else begin
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          acc_r <= is_div(op_r) ? div_next_s : mul_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= FIXUP;
          end
        end
        FIXUP: begin
          result  <= fix_result_s;
          state_r <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv
//   Self-checking bench for alu_muldiv (DWIDTH=32). Directed RV32M vectors,
//   randomized operations checked against a 64-bit arithmetic reference,
//   back-to-back, back-pressure, flush and asynchronous reset scenarios.
//   Latency is counted with the accept edge as edge 1, so the edge that
//   raises out_valid is number DW+2 (1 for fast-path operations).
module tb_alu_muldiv;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  // Reference: RV32M semantics via 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as, bs, au, bu, p;
    logic        ovf;
    as  = {{32{a[31]}}, a};
    bs  = {{32{b[31]}}, b};
    au  = {32'h0, a};
    bu  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = au * bu; return p[31:0]; end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * bu; return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: return (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 32'h0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MULDIV_FASTPATH_EN
    if (o[2]) begin
      if (b == 32'h0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    end else if (a == 32'h0 || b == 32'h0) begin
      return 1;
    end
`endif
    return DW + 2;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h0 - 32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for the accept, then wait for out_valid.
  // rdy_bad flags in_ready low at accept time or high while busy.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic rdy_bad);
    int n;
    rdy_bad = 1'b0;
    tick();
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) rdy_bad = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom); op_a = 32'($urandom); op_b = 32'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      tick();
      lat++;
    end
    if (in_ready) rdy_bad = 1'b1;
    res = result;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h expected 1 0 00000000", in_ready, out_valid, result);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [31:0] d_a  [14] = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd7, 32'd7, 32'd10, 32'd10, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h8000_0000};
  logic [31:0] d_b  [14] = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345, 32'd0};
  logic [31:0] d_e  [14] = '{32'd100, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd3, 32'd1, 32'hFFFF_FFFF, 32'd10, 32'h8000_0000, 32'h0, 32'h0, 32'h8000_0000};

  task automatic test_directed();
    int          lat;
    logic [31:0] res;
    logic        bad;
    for (int i = 0; i < 14; i++) begin
      start_op(d_op[i], d_a[i], d_b[i], lat, res, bad);
      checks++;
      if (res !== d_e[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: op=%0d result=%h expected %h", i, d_op[i], res, d_e[i]);
      end
      checks++;
      if (lat !== exp_lat(d_op[i], d_a[i], d_b[i])) begin
        errors++;
        $display("FAIL directed_latency[%0d]: edges=%0d expected %0d", i, lat, exp_lat(d_op[i], d_a[i], d_b[i]));
      end
      checks++;
      if (bad !== 1'b0) begin
        errors++;
        $display("FAIL directed_in_ready[%0d]: busy-ready violation=%b expected 0", i, bad);
      end
      finish_op();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_return_idle[%0d]: in_ready=%b out_valid=%b expected 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] res, a, b;
    logic [2:0]  o;
    logic        bad;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      start_op(o, a, b, lat, res, bad);
      checks++;
      if (res !== ref_model(o, a, b) || lat !== exp_lat(o, a, b) || bad !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h result=%h lat=%0d rdybad=%b expected %h lat=%0d rdybad=0",
                 i, o, a, b, res, lat, bad, ref_model(o, a, b), exp_lat(o, a, b));
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] res;
    logic        bad;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_op(3'(i * 3), 32'h1234_5678 + 32'(i), 32'd77 + 32'(i), lat, res, bad);
      checks++;
      if (res !== ref_model(3'(i * 3), 32'h1234_5678 + 32'(i), 32'd77 + 32'(i)) || bad !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back[%0d]: result=%h rdybad=%b expected %h rdybad=0",
                 i, res, bad, ref_model(3'(i * 3), 32'h1234_5678 + 32'(i), 32'd77 + 32'(i)));
      end
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    logic        bad;
    start_op(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, lat, res, bad);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== res) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b result=%h expected 1 0 %h",
                 i, out_valid, in_ready, result, res);
      end
    end
    checks++;
    if (res !== ref_model(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D)) begin
      errors++;
      $display("FAIL backpressure_result: result=%h expected %h", res, ref_model(3'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D));
    end
    finish_op();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    logic        seen;
    int          lat;
    logic        bad;
    prev = result;
    // Flush at the tenth CALC cycle
    tick();
    op = 3'd1; op_a = 32'h7654_3210; op_b = 32'h0000_1357; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mask_calc: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_to_idle: in_ready=%b expected 1", in_ready);
    end
    seen = 1'b0;
    repeat (DW + 5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || result !== prev) begin
      errors++;
      $display("FAIL flush_discard: out_valid_seen=%b result=%h expected 0 %h", seen, result, prev);
    end
    // flush with in_valid in IDLE: nothing accepted
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; op_a = 32'd3; op_b = 32'd4;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_mask_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_no_accept: in_ready=%b expected 1", in_ready);
    end
    // flush while DONE masks out_valid and drops the transfer
    start_op(3'd5, 32'd1000, 32'd7, lat, res, bad);
    flush = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mask_valid: out_valid=%b expected 0", out_valid);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd142) begin
      errors++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b result=%h expected 0 1 0000008e", out_valid, in_ready, result);
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] res;
    logic        bad;
    tick();
    op = 3'd4; op_a = 32'hFFFF_FF00; op_b = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b result=%h expected 1 0 00000000", in_ready, out_valid, result);
    end
    tick();
    rst = 1'b0;
    start_op(3'd6, 32'hFFFF_FF00, 32'd7, lat, res, bad);
    checks++;
    if (res !== ref_model(3'd6, 32'hFFFF_FF00, 32'd7) || lat !== DW + 2) begin
      errors++;
      $display("FAIL reset_recover: result=%h lat=%0d expected %h lat=%0d", res, lat, ref_model(3'd6, 32'hFFFF_FF00, 32'd7), DW + 2);
    end
    finish_op();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; op_a = 32'h0; op_b = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
